// File: rtl/stage_1_multi.sv
// Stage-one collector: launches NUM_CH part instances with one start pulse,
// captures each channel's half/square/CORDIC results in whatever order they
// finish (first done pulse wins) and offers the joined set downstream.
//
// Downstream handshake: out_valid rises when every channel of the latched
// mask has been captured (or the run times out) and then holds, together
// with out_*, captured and timeout, until a clock-enabled edge sees
// out_valid & out_ready; that edge drops out_valid and pulses done once.
module stage_1_multi #(
   parameter int FLT_DATA_WIDTH    = 32,
   parameter int CORDIC_DATA_WIDTH = 22,
   parameter int NUM_CH            = 4,
   parameter int TIMEOUT_CYCLES    = 255,
   parameter int TMO_W             = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clk_en,
   input  logic                                start,
   input  logic [NUM_CH-1:0]                   ch_mask,
   output logic                                part_start,
   input  logic [NUM_CH-1:0]                   part_done,
   input  logic [NUM_CH-1:0]                   part_working,
   input  logic [NUM_CH*FLT_DATA_WIDTH-1:0]    part_half,
   input  logic [NUM_CH*FLT_DATA_WIDTH-1:0]    part_square,
   input  logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] part_cordic,
   output logic [NUM_CH*FLT_DATA_WIDTH-1:0]    out_half,
   output logic [NUM_CH*FLT_DATA_WIDTH-1:0]    out_square,
   output logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] out_cordic,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_CH-1:0]                   captured,
   output logic                                timeout,
   output logic                                done,
   output logic                                working,
   output logic [1:0]                          dbg_state
);

   localparam int FW = FLT_DATA_WIDTH;
   localparam int CW = CORDIC_DATA_WIDTH;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [NUM_CH-1:0]              active_q;
   logic [NUM_CH-1:0]              captured_q;
   logic [TMO_W-1:0]               cnt_q;
   logic                           timeout_q;
   logic                           valid_q;
   logic                           ps_q;
   logic                           done_q;
   logic                           working_q;
   logic [NUM_CH*FW-1:0]           half_q;
   logic [NUM_CH*FW-1:0]           square_q;
   logic [NUM_CH*CW-1:0]           cordic_q;

   logic [NUM_CH-1:0]              cap_now;
   logic [NUM_CH-1:0]              cap_all;
   logic                           launch;
   logic                           complete;
   logic                           tmo_hit;
   logic                           accept;

   // Next-state and per-cycle strobes for the IDLE/COLLECT/HOLD controller.
   always_comb begin
      state_d  = state_q;
      cap_now  = '0;
      cap_all  = captured_q;
      launch   = 1'b0;
      complete = 1'b0;
      tmo_hit  = 1'b0;
      accept   = 1'b0;
      case (state_q)
         S_IDLE: begin
            launch = start && (ch_mask != '0);
            if (launch) state_d = S_COLLECT;
         end
         S_COLLECT: begin
            cap_now  = active_q & part_done & ~captured_q;
            cap_all  = captured_q | cap_now;
            complete = (cap_all == active_q);
            // Completion beats timeout when both land on the same cycle.
            tmo_hit  = !complete && (cnt_q == TMO_LAST);
            if (complete || tmo_hit) state_d = S_HOLD;
         end
         S_HOLD: begin
            accept = out_ready;
            if (accept) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; clk_en freezes the whole controller.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        state_q <= S_IDLE;
      else if (clk_en) state_q <= state_d;
   end

   // Run control: mask latch, capture flags, timeout counter and pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q   <= '0;
         captured_q <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
         ps_q       <= 1'b0;
         done_q     <= 1'b0;
         working_q  <= 1'b0;
      end else if (clk_en) begin
         working_q <= (state_q != S_IDLE) || (|part_working);
         ps_q      <= launch;
         done_q    <= accept;
         if (launch) begin
            active_q   <= ch_mask;
            captured_q <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
         end
         if (state_q == S_COLLECT) begin
            captured_q <= cap_all;
            cnt_q      <= cnt_q + 1'b1;
            if (complete) begin
               valid_q <= 1'b1;
            end else if (tmo_hit) begin
               valid_q   <= 1'b1;
               timeout_q <= 1'b1;
            end
         end
         if (accept) valid_q <= 1'b0;
      end
   end

   // Result registers: cleared at launch, loaded per channel on first capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_q   <= '0;
         square_q <= '0;
         cordic_q <= '0;
      end else if (clk_en) begin
         if (launch) begin
            half_q   <= '0;
            square_q <= '0;
            cordic_q <= '0;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (cap_now[i]) begin
                  half_q[i*FW +: FW]   <= part_half[i*FW +: FW];
                  square_q[i*FW +: FW] <= part_square[i*FW +: FW];
                  cordic_q[i*CW +: CW] <= part_cordic[i*CW +: CW];
               end
            end
         end
      end
   end

   // Pulses are masked by clk_en so a stalled cycle never shows one; the
   // underlying register holds, so a pending part_start is only delayed.
   assign part_start = ps_q & clk_en;
   assign done       = done_q & clk_en;
   assign out_valid  = valid_q;
   assign captured   = captured_q;
   assign timeout    = timeout_q;
   assign working    = working_q;
   assign out_half   = half_q;
   assign out_square = square_q;
   assign out_cordic = cordic_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_stage_1_multi.sv
// Bench for stage_1_multi: table of runs (mask, per-channel done cycles,
// expected completion cycle / captured / timeout), a data model feeding an
// expected-result queue, plus hand sequences for reset, stall and ignores.
module tb_stage_1_multi;

   localparam int NC = 4;
   localparam int FW = 32;
   localparam int CW = 22;
   localparam int TO = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              clk_en = 1'b1;
   logic              start = 1'b0;
   logic [NC-1:0]     ch_mask = '0;
   logic              part_start;
   logic [NC-1:0]     part_done = '0;
   logic [NC-1:0]     part_working = '0;
   logic [NC*FW-1:0]  part_half = '0;
   logic [NC*FW-1:0]  part_square = '0;
   logic [NC*CW-1:0]  part_cordic = '0;
   logic [NC*FW-1:0]  out_half;
   logic [NC*FW-1:0]  out_square;
   logic [NC*CW-1:0]  out_cordic;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [NC-1:0]     captured;
   logic              timeout;
   logic              done;
   logic              working;
   logic [1:0]        dbg_state;

   stage_1_multi #(
      .FLT_DATA_WIDTH(FW), .CORDIC_DATA_WIDTH(CW), .NUM_CH(NC),
      .TIMEOUT_CYCLES(TO), .TMO_W(8)
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .ch_mask(ch_mask),
      .part_start(part_start), .part_done(part_done), .part_working(part_working),
      .part_half(part_half), .part_square(part_square), .part_cordic(part_cordic),
      .out_half(out_half), .out_square(out_square), .out_cordic(out_cordic),
      .out_valid(out_valid), .out_ready(out_ready), .captured(captured),
      .timeout(timeout), .done(done), .working(working), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- records ----------------
   typedef struct packed {
      logic [NC*FW-1:0] half;
      logic [NC*FW-1:0] square;
      logic [NC*CW-1:0] cordic;
      logic [NC-1:0]    cap;
      logic             tmo;
   } result_t;
   localparam int RW = $bits(result_t);

   // done_at / dup_at: one byte per channel {ch3,ch2,ch1,ch0}, 8'hFF = never.
   // last: COLLECT cycle index (0 = part_start cycle) that ends the run.
   typedef struct packed {
      logic [NC-1:0]      mask;
      logic [NC-1:0][7:0] done_at;
      logic [NC-1:0][7:0] dup_at;
      logic [7:0]         last;
      logic [NC-1:0]      cap;
      logic               tmo;
      logic               fixed;
   } vec_t;

   logic [RW-1:0] exp_q[$];
   vec_t          vecs[9];
   int            total = 0;
   int            bad = 0;

   function automatic vec_t mk(input logic [3:0] m, input logic [31:0] d,
                               input logic [31:0] u, input int l,
                               input logic [3:0] c, input logic t, input logic f);
      vec_t v;
      v.mask = m; v.done_at = d; v.dup_at = u; v.last = 8'(l);
      v.cap = c; v.tmo = t; v.fixed = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   // ---------------- driver: one table run ----------------
   // Called at a negedge with the DUT in IDLE; returns at the negedge where
   // done is high, so the next call starts back-to-back.
   task automatic run_vec(input int vi, input bit stall);
      vec_t       v;
      result_t    e, g;
      logic [3:0] seen;
      logic [3:0] pd;
      logic [31:0] h, s;
      logic [21:0] c;
      int         l;
      v = vecs[vi];
      l = int'(v.last);
      e = '0;
      seen = '0;
      start = 1'b1; ch_mask = v.mask; clk_en = 1'b1; out_ready = 1'b0; part_done = '0;
      @(negedge clk);
      start = 1'b0;
      ch_mask = 4'($urandom_range(0, 15));
      chk($sformatf("v%0d part_start", vi), part_start, 1);
      chk($sformatf("v%0d done_low_at_start", vi), done, 0);
      chk($sformatf("v%0d cleared", vi), {captured, timeout, out_half[63:0]}, 0);
      for (int k = 0; k <= l + 1; k++) begin
         chk($sformatf("v%0d valid_c%0d", vi, k), out_valid, (k == l + 1));
         if (k >= 1) chk($sformatf("v%0d ps_low_c%0d", vi, k), part_start, 0);
         if (k == l + 1) break;
         pd = '0;
         for (int ch = 0; ch < NC; ch++) begin
            h = $urandom; s = $urandom; c = 22'($urandom);
            if ((int'(v.done_at[ch]) == k) || (int'(v.dup_at[ch]) == k)) begin
               if (v.fixed) begin h = 32'h3F000000; s = 32'h3F800000; c = 22'h100000; end
               pd[ch] = 1'b1;
               if (v.mask[ch] && !seen[ch]) begin
                  seen[ch] = 1'b1;
                  e.half[ch*FW +: FW] = h;
                  e.square[ch*FW +: FW] = s;
                  e.cordic[ch*CW +: CW] = c;
               end
            end
            part_half[ch*FW +: FW] = h;
            part_square[ch*FW +: FW] = s;
            part_cordic[ch*CW +: CW] = c;
         end
         part_done = pd;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      part_done = '0;
      out_ready = 1'b0;
      e.cap = v.cap;
      e.tmo = v.tmo;
      exp_q.push_back(e);
      // DUT has produced a result set: pop and compare.
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL v%0d scoreboard_empty got=none want=entry", vi);
      end else begin
         g = result_t'(exp_q.pop_front());
         chk($sformatf("v%0d out_half", vi), out_half, g.half);
         chk($sformatf("v%0d out_square", vi), out_square, g.square);
         chk($sformatf("v%0d out_cordic", vi), out_cordic, g.cordic);
         chk($sformatf("v%0d captured", vi), captured, g.cap);
         chk($sformatf("v%0d timeout", vi), timeout, g.tmo);
         if (stall) begin
            for (int j = 0; j < 20; j++) begin
               start = 1'($urandom_range(0, 1));
               ch_mask = 4'hF;
               clk_en = 1'($urandom_range(0, 1));
               @(negedge clk);
               chk($sformatf("v%0d stall_ctl%0d", vi, j), {out_valid, part_start, done}, 3'b100);
               chk($sformatf("v%0d stall_half%0d", vi, j), out_half, g.half);
               chk($sformatf("v%0d stall_cap%0d", vi, j), {captured, timeout}, {g.cap, g.tmo});
            end
            start = 1'b0;
            clk_en = 1'b1;
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("v%0d done_pulse", vi), {done, out_valid}, 2'b10);
         chk($sformatf("v%0d kept_after_done", vi), {captured, timeout, out_cordic}, {g.cap, g.tmo, g.cordic});
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = mk(4'hF, 32'h05050505, 32'hFFFFFFFF, 5, 4'hF, 1'b0, 1'b1);
      vecs[1] = mk(4'hF, 32'h06000803, 32'hFF03FFFF, 8, 4'hF, 1'b0, 1'b0);
      vecs[2] = mk(4'h5, 32'hFF040201, 32'hFFFFFFFF, 4, 4'h5, 1'b0, 1'b0);
      vecs[3] = mk(4'hF, 32'hFF030201, 32'hFFFFFFFF, 9, 4'h7, 1'b1, 1'b0);
      vecs[4] = mk(4'hF, 32'h09000407, 32'hFFFFFFFF, 9, 4'hF, 1'b0, 1'b0);
      vecs[5] = mk(4'h1, 32'hFF00FF00, 32'hFFFFFFFF, 0, 4'h1, 1'b0, 1'b0);
      vecs[6] = mk(4'h8, 32'hFFFFFF02, 32'hFFFFFFFF, 9, 4'h0, 1'b1, 1'b0);
      vecs[7] = mk(4'hA, 32'h02FF0201, 32'hFFFFFFFF, 2, 4'hA, 1'b0, 1'b0);
      vecs[8] = mk(4'hF, 32'h00000000, 32'hFFFFFFFF, 0, 4'hF, 1'b0, 1'b0);

      // Reset state.
      #1;
      chk("reset_outputs", {out_valid, part_start, done, working, timeout, captured, out_half[31:0]}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {out_valid, part_start, dbg_state}, 0);

      // start with empty mask, and start while clk_en=0: both ignored.
      start = 1'b1; ch_mask = 4'h0;
      @(negedge clk);
      chk("zero_mask_ignored", {part_start, dbg_state}, 0);
      ch_mask = 4'hF; clk_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("clk_en_blocks_start", {part_start, dbg_state}, 0);
      start = 1'b0; clk_en = 1'b1;
      @(negedge clk);
      chk("no_late_launch", {part_start, dbg_state}, 0);

      // working follows part_working one edge later.
      part_working = 4'h2;
      @(negedge clk);
      chk("working_from_parts", working, 1);
      part_working = 4'h0;
      @(negedge clk);
      chk("working_idle", working, 0);

      // Table runs, back-to-back; run 0 also stalls in HOLD.
      run_vec(0, 1'b1);
      for (int i = 1; i < 9; i++) run_vec(i, 1'b0);
      @(negedge clk);
      chk("done_single_pulse", done, 0);

      // Asynchronous reset mid-COLLECT after two captures.
      start = 1'b1; ch_mask = 4'hF;
      @(negedge clk);
      start = 1'b0;
      part_done = 4'h1; part_half = {4{32'h12345678}};
      @(negedge clk);
      part_done = 4'h2;
      @(negedge clk);
      part_done = 4'h0;
      chk("pre_reset_captured", {captured, working}, {4'h3, 1'b1});
      #2 rst = 1'b0;
      #1;
      chk("async_reset_clears", {out_valid, part_start, done, working, timeout, captured, dbg_state, out_half[63:0]}, 0);
      @(negedge clk);
      rst = 1'b1;
      run_vec(0, 1'b0);
      @(negedge clk);
      chk("post_reset_idle", {done, out_valid, dbg_state}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
